// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between the pipeline
// writeback, a buffered multi-cycle result and the debug module.
// It also keeps a scoreboard of registers awaiting multi-cycle results.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   pipe_wr_en/addr/data              writeback request (highest priority)
//   mc_issue_valid/addr               multi-cycle op issued to a register
//   mc_res_valid/addr/data, ready     multi-cycle result handshake
//   dbg_req/addr/wdata, dbg_gnt       debug write request and grant
//   id_rs1/rs2/dst_*                  decode-stage register operands
//   hazard_stall, wb_stall, busy      stall and status outputs
//   rf_wr_en/addr/data                register file write port
module rf_wb_arbiter #(
    parameter int REG_NUM    = 32,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_wr_en,
    input  logic [ADDR_W-1:0] pipe_wr_addr,
    input  logic [DATA_W-1:0] pipe_wr_data,
    input  logic              mc_issue_valid,
    input  logic [ADDR_W-1:0] mc_issue_addr,
    input  logic              mc_res_valid,
    input  logic [ADDR_W-1:0] mc_res_addr,
    input  logic [DATA_W-1:0] mc_res_data,
    output logic              mc_res_ready,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    input  logic [ADDR_W-1:0] id_rs1_addr,
    input  logic [ADDR_W-1:0] id_rs2_addr,
    input  logic              id_dst_valid,
    input  logic [ADDR_W-1:0] id_dst_addr,
    output logic              hazard_stall,
    output logic              wb_stall,
    output logic              busy,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data
);

    localparam int AGE_W = $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

    logic               hold_valid;
    logic [ADDR_W-1:0]  hold_addr;
    logic [DATA_W-1:0]  hold_data;
    logic [REG_NUM-1:0] pending;
    logic [AGE_W-1:0]   age;
    logic [AGE_W-1:0]   age_nxt;

    logic               pipe_act;
    logic               hold_act;
    logic               hold_win;
    logic               drain;
    logic               capture;
    logic [REG_NUM-1:0] drain_mask;
    logic [REG_NUM-1:0] issue_mask;
    logic [REG_NUM-1:0] hazard_vec;

    // Address-0 requests never occupy the port.
    assign pipe_act = pipe_wr_en && (pipe_wr_addr != '0);
    assign hold_act = hold_valid && (hold_addr != '0);
    assign hold_win = hold_act && !pipe_act;

    // A held x0 result retires at once, even while the pipe writes.
    assign drain   = hold_valid && ((hold_addr == '0) || !pipe_act);
    assign capture = mc_res_valid && !hold_valid;

    assign mc_res_ready = !hold_valid;
    assign dbg_gnt = dbg_req && !pipe_act && !hold_act
                     && !pending[dbg_addr];

    always_comb begin
        drain_mask = '0;
        issue_mask = '0;
        if (drain)
            drain_mask[hold_addr] = 1'b1;
        if (mc_issue_valid && (mc_issue_addr != '0))
            issue_mask[mc_issue_addr] = 1'b1;
    end

    // The draining register is forwarded by the register file, so it
    // no longer counts as a hazard in its drain cycle.
    assign hazard_vec   = pending & ~drain_mask;
    assign hazard_stall = hazard_vec[id_rs1_addr]
                          | hazard_vec[id_rs2_addr]
                          | (id_dst_valid & hazard_vec[id_dst_addr]);
    assign busy = |pending;

    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        unique case (1'b1)
            pipe_act: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = pipe_wr_addr;
                rf_wr_data = pipe_wr_data;
            end
            hold_win: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = hold_addr;
                rf_wr_data = hold_data;
            end
            (dbg_gnt && (dbg_addr != '0)): begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = dbg_addr;
                rf_wr_data = dbg_wdata;
            end
            default: ;
        endcase
    end

    // Age counts losses to the pipe while a result waits.
    always_comb begin
        age_nxt = age;
        if (drain || !hold_valid)
            age_nxt = '0;
        else if (age != AGE_MAX)
            age_nxt = age + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            pending    <= '0;
            age        <= '0;
            wb_stall   <= 1'b0;
        end else begin
            // Issue is OR-ed last so a same-edge set beats the clear.
            pending <= (pending & ~drain_mask) | issue_mask;
            age     <= age_nxt;
            if (drain) begin
                hold_valid <= 1'b0;
            end else if (capture) begin
                hold_valid <= 1'b1;
                hold_addr  <= mc_res_addr;
                hold_data  <= mc_res_data;
            end
            if (drain)
                wb_stall <= 1'b0;
            else if (hold_valid && (age_nxt == AGE_MAX))
                wb_stall <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: vector table, directed corner sequences and a
// randomized run against a behavioural model of the write-port arbiter.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_addr;
    logic [31:0] pipe_wr_data;
    logic        mc_issue_valid;
    logic [4:0]  mc_issue_addr;
    logic        mc_res_valid;
    logic [4:0]  mc_res_addr;
    logic [31:0] mc_res_data;
    logic        mc_res_ready;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_dst_valid;
    logic [4:0]  id_dst_addr;
    logic        hazard_stall;
    logic        wb_stall;
    logic        busy;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(
        .REG_NUM(32), .ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr),
        .pipe_wr_data(pipe_wr_data),
        .mc_issue_valid(mc_issue_valid), .mc_issue_addr(mc_issue_addr),
        .mc_res_valid(mc_res_valid), .mc_res_addr(mc_res_addr),
        .mc_res_data(mc_res_data), .mc_res_ready(mc_res_ready),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_dst_valid(id_dst_valid), .id_dst_addr(id_dst_addr),
        .hazard_stall(hazard_stall), .wb_stall(wb_stall), .busy(busy),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic pe; logic [4:0] pa; logic [31:0] pd;
        logic iv; logic [4:0] ia;
        logic rv; logic [4:0] ra; logic [31:0] rd;
        logic dr; logic [4:0] da; logic [31:0] dd;
        logic [4:0] rs1;
        logic en; logic [4:0] wa; logic [31:0] wd;
        logic rdy; logic gnt; logic hz; logic bsy; logic ws;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic pe, logic [4:0] pa, logic [31:0] pd,
        logic iv, logic [4:0] ia,
        logic rv, logic [4:0] ra, logic [31:0] rd,
        logic dr, logic [4:0] da, logic [31:0] dd,
        logic [4:0] rs1,
        logic en, logic [4:0] wa, logic [31:0] wd,
        logic rdy, logic gnt, logic hz, logic bsy, logic ws);
        vec_t v;
        v = '{pe, pa, pd, iv, ia, rv, ra, rd, dr, da, dd, rs1,
              en, wa, wd, rdy, gnt, hz, bsy, ws};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    task automatic check_out(input string tag,
        input logic en, input logic [4:0] wa, input logic [31:0] wd,
        input logic rdy, input logic gnt, input logic hz,
        input logic bsy, input logic ws);
        chk({tag, ".rf_wr_en"}, 32'(rf_wr_en), 32'(en));
        chk({tag, ".rf_wr_addr"}, 32'(rf_wr_addr), 32'(wa));
        chk({tag, ".rf_wr_data"}, rf_wr_data, wd);
        chk({tag, ".mc_res_ready"}, 32'(mc_res_ready), 32'(rdy));
        chk({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'(gnt));
        chk({tag, ".hazard_stall"}, 32'(hazard_stall), 32'(hz));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".wb_stall"}, 32'(wb_stall), 32'(ws));
    endtask

    task automatic idle();
        pipe_wr_en = 0; pipe_wr_addr = 0; pipe_wr_data = 0;
        mc_issue_valid = 0; mc_issue_addr = 0;
        mc_res_valid = 0; mc_res_addr = 0; mc_res_data = 0;
        dbg_req = 0; dbg_addr = 0; dbg_wdata = 0;
        id_rs1_addr = 0; id_rs2_addr = 0;
        id_dst_valid = 0; id_dst_addr = 0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state.
    bit        m_hv;
    bit [4:0]  m_ha;
    bit [31:0] m_hd;
    bit        m_pend[32];
    int        m_loss;
    bit        m_ws;

    logic        e_en, e_rdy, e_gnt, e_hz, e_bsy;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    bit          e_drain;

    function automatic bit m_hazard(input bit [4:0] a);
        return m_pend[a] && !(e_drain && a == m_ha);
    endfunction

    task automatic model_eval();
        bit pipe_use, hold_busy;
        pipe_use  = pipe_wr_en && pipe_wr_addr != 0;
        hold_busy = m_hv && m_ha != 0;
        e_drain   = m_hv && (m_ha == 0 || !pipe_use);
        e_gnt     = dbg_req && !pipe_use && !hold_busy
                    && !m_pend[dbg_addr];
        e_en = 0; e_wa = 0; e_wd = 0;
        if (pipe_use) begin
            e_en = 1; e_wa = pipe_wr_addr; e_wd = pipe_wr_data;
        end else if (hold_busy) begin
            e_en = 1; e_wa = m_ha; e_wd = m_hd;
        end else if (e_gnt && dbg_addr != 0) begin
            e_en = 1; e_wa = dbg_addr; e_wd = dbg_wdata;
        end
        e_rdy = !m_hv;
        e_bsy = 0;
        foreach (m_pend[i]) if (m_pend[i]) e_bsy = 1;
        e_hz = m_hazard(id_rs1_addr) || m_hazard(id_rs2_addr)
               || (id_dst_valid && m_hazard(id_dst_addr));
    endtask

    task automatic model_edge();
        bit was_hv;
        was_hv = m_hv;
        if (e_drain) begin
            m_pend[m_ha] = 0;
            m_hv = 0;
            m_loss = 0;
            m_ws = 0;
        end else if (m_hv) begin
            m_loss++;
            if (m_loss >= 4) m_ws = 1;
        end
        if (!was_hv && mc_res_valid) begin
            m_hv = 1; m_ha = mc_res_addr; m_hd = mc_res_data;
        end
        if (mc_issue_valid && mc_issue_addr != 0)
            m_pend[mc_issue_addr] = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #2;
        check_out("reset", 0, 0, 0, 1, 0, 0, 0, 0);
        adv();
        rst_n = 1;

        // Table: divider x5, pipe/hold/debug priority, x0 requests.
        tbl.push_back(mk(0,0,0, 1,5, 0,0,0, 0,0,0, 5,
                         0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0, 5,
                         0,0,0, 1,0,1,1,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0, 5,
                         0,0,0, 1,0,1,1,0));
        tbl.push_back(mk(0,0,0, 0,0, 1,5,32'hDEADBEEF, 0,0,0, 5,
                         0,0,0, 1,0,1,1,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0, 5,
                         1,5,32'hDEADBEEF, 0,0,0,1,0));
        tbl.push_back(mk(0,0,0, 1,4, 0,0,0, 0,0,0, 4,
                         0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0, 1,4,32'h44444444, 0,0,0, 4,
                         0,0,0, 1,0,1,1,0));
        tbl.push_back(mk(1,3,32'h33, 0,0, 0,0,0, 1,9,32'h99, 4,
                         1,3,32'h33, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 1,9,32'h99, 4,
                         1,4,32'h44444444, 0,0,0,1,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 1,9,32'h99, 4,
                         1,9,32'h99, 1,1,0,0,0));
        tbl.push_back(mk(0,0,0, 1,0, 1,0,32'h1234, 0,0,0, 0,
                         0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 1,9,32'hAA, 0,
                         1,9,32'hAA, 0,1,0,0,0));
        tbl.push_back(mk(1,0,32'hFFFF, 0,0, 0,0,0, 1,2,32'h22, 0,
                         1,2,32'h22, 1,1,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            pipe_wr_en = v.pe; pipe_wr_addr = v.pa; pipe_wr_data = v.pd;
            mc_issue_valid = v.iv; mc_issue_addr = v.ia;
            mc_res_valid = v.rv; mc_res_addr = v.ra; mc_res_data = v.rd;
            dbg_req = v.dr; dbg_addr = v.da; dbg_wdata = v.dd;
            id_rs1_addr = v.rs1;
            @(negedge clk);
            check_out($sformatf("vec%0d", i), v.en, v.wa, v.wd,
                      v.rdy, v.gnt, v.hz, v.bsy, v.ws);
            adv();
        end

        // Starvation: x7 held while the pipe writes x1 every cycle.
        idle();
        mc_issue_valid = 1; mc_issue_addr = 7; id_rs1_addr = 7;
        @(negedge clk);
        check_out("starve.issue", 0, 0, 0, 1, 0, 0, 0, 0);
        adv();
        mc_issue_valid = 0;
        mc_res_valid = 1; mc_res_addr = 7; mc_res_data = 32'h77;
        pipe_wr_en = 1; pipe_wr_addr = 1; pipe_wr_data = 100;
        @(negedge clk);
        check_out("starve.cap", 1, 1, 100, 1, 0, 1, 1, 0);
        adv();
        mc_res_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            pipe_wr_data = 100 + k;
            @(negedge clk);
            check_out($sformatf("starve.loss%0d", k), 1, 1, 100 + k,
                      0, 0, 1, 1, k >= 5);
            adv();
        end
        pipe_wr_en = 0;
        @(negedge clk);
        check_out("starve.drain", 1, 7, 32'h77, 0, 0, 0, 1, 1);
        adv();
        @(negedge clk);
        check_out("starve.after", 0, 0, 0, 1, 0, 0, 0, 0);
        adv();

        // Debug write blocked by a pending register.
        idle();
        mc_issue_valid = 1; mc_issue_addr = 6; id_rs1_addr = 6;
        adv();
        mc_issue_valid = 0;
        dbg_req = 1; dbg_addr = 6; dbg_wdata = 32'h66;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_out("dbgpend.wait", 0, 0, 0, 1, 0, 1, 1, 0);
            adv();
        end
        mc_res_valid = 1; mc_res_addr = 6; mc_res_data = 32'h60;
        @(negedge clk);
        check_out("dbgpend.res", 0, 0, 0, 1, 0, 1, 1, 0);
        adv();
        mc_res_valid = 0;
        @(negedge clk);
        check_out("dbgpend.drain", 1, 6, 32'h60, 0, 0, 0, 1, 0);
        adv();
        @(negedge clk);
        check_out("dbgpend.gnt", 1, 6, 32'h66, 1, 1, 0, 0, 0);
        adv();

        // Reset while a result for x10 is held.
        idle();
        mc_issue_valid = 1; mc_issue_addr = 10; id_rs1_addr = 10;
        adv();
        mc_issue_valid = 0;
        mc_res_valid = 1; mc_res_addr = 10; mc_res_data = 32'hAA;
        pipe_wr_en = 1; pipe_wr_addr = 1; pipe_wr_data = 5;
        adv();
        mc_res_valid = 0;
        @(negedge clk);
        check_out("rst.pre", 1, 1, 5, 0, 0, 1, 1, 0);
        #1;
        pipe_wr_en = 0;
        rst_n = 0;
        #1;
        check_out("rst.mid", 0, 0, 0, 1, 0, 0, 0, 0);
        adv();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_out("rst.post", 0, 0, 0, 1, 0, 0, 0, 0);
            adv();
        end

        // Randomized run against the model (DUT is empty here).
        idle();
        m_hv = 0; m_ha = 0; m_hd = 0; m_loss = 0; m_ws = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        e_gnt = 0;
        for (int c = 0; c < 400; c++) begin
            if (m_ws && $urandom_range(0, 4) != 0)
                pipe_wr_en = 0;
            else
                pipe_wr_en = ($urandom_range(0, 2) == 0);
            pipe_wr_addr = 5'($urandom_range(0, 7));
            pipe_wr_data = $urandom;
            mc_issue_valid = ($urandom_range(0, 3) == 0);
            mc_issue_addr = 5'($urandom_range(0, 7));
            mc_res_valid = ($urandom_range(0, 2) == 0);
            mc_res_addr = 5'($urandom_range(0, 7));
            mc_res_data = $urandom;
            if (dbg_req && e_gnt)
                dbg_req = 0;
            else if (!dbg_req && $urandom_range(0, 3) == 0) begin
                dbg_req = 1;
                dbg_addr = 5'($urandom_range(0, 7));
                dbg_wdata = $urandom;
            end
            id_rs1_addr = 5'($urandom_range(0, 7));
            id_rs2_addr = 5'($urandom_range(0, 7));
            id_dst_valid = $urandom_range(0, 1);
            id_dst_addr = 5'($urandom_range(0, 7));
            model_eval();
            @(negedge clk);
            check_out($sformatf("rand%0d", c), e_en, e_wa, e_wd,
                      e_rdy, e_gnt, e_hz, e_bsy, m_ws);
            model_edge();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard in front of the general-purpose register file. It shares the register file's single write port between three requesters: the pipeline writeback stage, the multi-cycle unit (divider) result path, and the debug module. It tracks registers with outstanding multi-cycle results and raises decode-stage hazard stalls against them. It sits between the writeback stage and the register file's wr_en/wr_addr/wr_data inputs.

## Interface
- REG_NUM, 32: number of architectural registers
- ADDR_W, 5: register address width
- DATA_W, 32: register data width
- STARVE_MAX, 4: cycles a buffered multi-cycle result may wait before a writeback stall is forced
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- pipe_wr_en / pipe_wr_addr / pipe_wr_data  in  1/ADDR_W/DATA_W  pipeline writeback request (never back-pressured)
- mc_issue_valid / mc_issue_addr  in  1/ADDR_W  multi-cycle op issued with this destination
- mc_res_valid / mc_res_addr / mc_res_data  in  1/ADDR_W/DATA_W  multi-cycle result offer
- mc_res_ready  out  1  result accepted when valid && ready at a clk edge
- dbg_req / dbg_addr / dbg_wdata  in  1/ADDR_W/DATA_W  debug write request, held until granted
- dbg_gnt  out  1  one-cycle grant; debug write performed in that cycle
- id_rs1_addr / id_rs2_addr  in  ADDR_W  decode-stage source registers
- id_dst_valid / id_dst_addr  in  1/ADDR_W  decode-stage destination register
- hazard_stall  out  1  decode must stall
- wb_stall  out  1  core must hold pipe_wr_en low while asserted
- busy  out  1  any scoreboard bit set
- rf_wr_en / rf_wr_addr / rf_wr_data  out  1/ADDR_W/DATA_W  to register file write port

## Operation
- State: one-entry hold buffer (hold_valid, hold_addr, hold_data), pending[REG_NUM] scoreboard, age counter (width clog2(STARVE_MAX+1)), wb_stall register.
- mc_res_ready = !hold_valid. On handshake, capture addr/data; hold_valid <= 1 at that edge.
- Port arbitration each cycle, fixed priority: pipe > hold > debug. The winner drives rf_wr_*; with no winner, rf_wr_en=0 and addr/data=0.
- Any request to address 0 never asserts rf_wr_en and does not consume the port, so a lower requester may win that cycle. A held address-0 result drains immediately without a write.
- Hold drains when it wins: hold_valid <= 0 and pending[hold_addr] <= 0 at that edge. Drain and a new capture cannot coincide (ready was low).
- Debug wins only when pipe and hold are idle and pending[dbg_addr]==0. Then dbg_gnt=1 combinationally and the write occurs that cycle.
- Scoreboard set: mc_issue_valid with addr != 0 sets pending[addr]. A set and a clear on the same address in the same edge: set wins.
- hazard_stall = pending[id_rs1_addr] | pending[id_rs2_addr] | (id_dst_valid & pending[id_dst_addr]). Address 0 is never pending.
- busy = |pending.
- Starvation: age increments each cycle hold_valid && hold loses to pipe, and clears when the hold drains or is empty. When age reaches STARVE_MAX, wb_stall <= 1. wb_stall clears at the edge the hold drains. If pipe_wr_en is asserted despite wb_stall, pipe still wins and wb_stall stays high.

## Timing
- Reset (async): hold_valid=0, pending all 0, age=0, wb_stall=0. So mc_res_ready=1, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, dbg_gnt=0, hazard_stall=0, busy=0.
- Reset mid-operation discards any buffered result and all pending bits.
- rf_wr_*, dbg_gnt, hazard_stall and busy are combinational from inputs and state. The register file samples rf_wr_* at the next clk edge.
- Result accepted at edge N: earliest rf_wr_en from hold is cycle N..N+1; mc_res_ready is low in that cycle. Ready rises after the drain edge, so back-to-back results are sustained at 1 per 2 cycles.
- Issue at edge N: hazard_stall reflects the new pending bit from cycle N+1.
- The pending bit clears at the drain edge. A decode read in the drain cycle is satisfied by register-file write forwarding, so hazard_stall is already 0 in the drain cycle.
- Worst-case hold wait: STARVE_MAX cycles plus 1 cycle for wb_stall to register.

## Test plan
- Issue div to x5; result 0xDEADBEEF offered 3 cycles later with no pipe traffic -> hazard_stall for rs1=5 until the drain cycle; rf_wr_en=1, addr 5, data 0xDEADBEEF for one cycle; busy falls after the drain edge.
- Pipe writes x1 every cycle while a result for x7 is held, STARVE_MAX=4 -> wb_stall rises after 4 losses. Once pipe_wr_en drops, x7 is written and wb_stall clears the next edge.
- Pipe write x3, hold x4 and debug x9 in the same cycle -> x3 written first, x4 next cycle, then dbg_gnt and the x9 write.
- Debug write to pending x6 -> dbg_gnt stays 0 until x6's result drains, then is granted the next idle cycle.
- Issue to x0 and result to x0 -> no pending bit, mc_res_ready handshakes, rf_wr_en never asserted for x0; a simultaneous debug write wins the port that cycle.
- Assert rst_n low while hold_valid=1 and x10 is pending -> all outputs return to reset values immediately; no write to x10 after reset releases.
